// File: rtl/prio_arb_ctrl.sv
// Eight-way priority arbiter with registered one-hot grant, hold-until-done
// ownership, optional round-robin rotation and a hold-time watchdog.
module prio_arb_ctrl #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       done,
    input  logic       mode,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_vld,
    output logic       timeout
);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    localparam bit WD_EN = (MAX_HOLD != 0);
    localparam int HOLD_LAST_I = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;
    localparam logic [CNT_W-1:0] HOLD_LAST = HOLD_LAST_I[CNT_W-1:0];

    state_t           state_q, state_d;
    logic [7:0]       gnt_q, gnt_d;
    logic [2:0]       gnt_idx_q, gnt_idx_d;
    logic             gnt_vld_q, gnt_vld_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [2:0]       ptr_q, ptr_d;

    logic             win_found;
    logic [2:0]       win_idx;
    logic [2:0]       cand;
    logic             owner_req;
    logic             expire;

    // Winner select: fixed scans 7..0; round-robin scans ptr-1 downward, wrapping, ending at ptr.
    always_comb begin
        win_found = 1'b0;
        win_idx   = 3'd0;
        cand      = 3'd0;
        if (mode) begin
            for (int i = 1; i <= 8; i++) begin
                cand = ptr_q - 3'(i);
                if (!win_found && req[cand]) begin
                    win_found = 1'b1;
                    win_idx   = cand;
                end
            end
        end else begin
            for (int i = 7; i >= 0; i--) begin
                if (!win_found && req[i]) begin
                    win_found = 1'b1;
                    win_idx   = 3'(i);
                end
            end
        end
    end

    assign owner_req = req[gnt_idx_q];
    assign expire    = WD_EN && (hold_cnt_q == HOLD_LAST);

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        gnt_idx_d  = gnt_idx_q;
        gnt_vld_d  = gnt_vld_q;
        timeout_d  = 1'b0;
        hold_cnt_d = hold_cnt_q;
        ptr_d      = ptr_q;
        case (state_q)
            IDLE: begin
                gnt_d      = 8'h00;
                gnt_idx_d  = 3'd0;
                gnt_vld_d  = 1'b0;
                hold_cnt_d = '0;
                if (win_found) begin
                    gnt_d     = 8'h01 << win_idx;
                    gnt_idx_d = win_idx;
                    gnt_vld_d = 1'b1;
                    ptr_d     = win_idx;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                if (done || !owner_req || expire) begin
                    gnt_d      = 8'h00;
                    gnt_idx_d  = 3'd0;
                    gnt_vld_d  = 1'b0;
                    hold_cnt_d = '0;
                    state_d    = IDLE;
                    // Only a pure watchdog expiry is reported as a timeout.
                    timeout_d  = expire && !done && owner_req;
                end else begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d    = IDLE;
                gnt_d      = 8'h00;
                gnt_idx_d  = 3'd0;
                gnt_vld_d  = 1'b0;
                hold_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= 8'h00;
            gnt_idx_q  <= 3'd0;
            gnt_vld_q  <= 1'b0;
            timeout_q  <= 1'b0;
            hold_cnt_q <= '0;
            ptr_q      <= 3'd0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            gnt_idx_q  <= gnt_idx_d;
            gnt_vld_q  <= gnt_vld_d;
            timeout_q  <= timeout_d;
            hold_cnt_q <= hold_cnt_d;
            ptr_q      <= ptr_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_idx = gnt_idx_q;
    assign gnt_vld = gnt_vld_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_prio_arb_ctrl.sv
// Directed self-checking bench for prio_arb_ctrl, built with a 4-cycle watchdog.
module tb_prio_arb_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic       mode;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_vld;
    logic       timeout;

    int total = 0;
    int bad   = 0;

    // Packed view of all outputs: {gnt, gnt_idx, gnt_vld, timeout}.
    logic [12:0] obs;
    assign obs = {gnt, gnt_idx, gnt_vld, timeout};

    prio_arb_ctrl #(.MAX_HOLD(4), .CNT_W(3)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .mode    (mode),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL sim_timeout got=running want=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    task automatic do_reset();
        @(negedge clk);
        rst  = 1'b1;
        req  = 8'h00;
        done = 1'b0;
        @(negedge clk);
        rst  = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst  = 1'b1;
        req  = 8'hFF;
        done = 1'b0;
        mode = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total++;
            if (obs !== {8'h00, 3'd0, 1'b0, 1'b0}) begin
                bad++;
                $display("[TB] FAIL reset_hold[%0d] got gnt=%h idx=%0d vld=%b to=%b want 00/0/0/0", i, gnt, gnt_idx, gnt_vld, timeout);
            end
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (obs !== {8'h80, 3'd7, 1'b1, 1'b0}) begin
            bad++;
            $display("[TB] FAIL reset_first_grant got gnt=%h idx=%0d vld=%b to=%b want 80/7/1/0", gnt, gnt_idx, gnt_vld, timeout);
        end
    endtask

    task automatic test_fixed();
        do_reset();
        mode = 1'b0;
        req  = 8'h2C;
        @(negedge clk);
        total++;
        if (obs !== {8'h20, 3'd5, 1'b1, 1'b0}) begin
            bad++;
            $display("[TB] FAIL fixed_first got gnt=%h idx=%0d vld=%b to=%b want 20/5/1/0", gnt, gnt_idx, gnt_vld, timeout);
        end
        done = 1'b1;
        req  = 8'h0C;
        @(negedge clk);
        done = 1'b0;
        total++;
        if (obs !== {8'h00, 3'd0, 1'b0, 1'b0}) begin
            bad++;
            $display("[TB] FAIL fixed_release got gnt=%h idx=%0d vld=%b to=%b want 00/0/0/0", gnt, gnt_idx, gnt_vld, timeout);
        end
        @(negedge clk);
        total++;
        if (obs !== {8'h08, 3'd3, 1'b1, 1'b0}) begin
            bad++;
            $display("[TB] FAIL fixed_second got gnt=%h idx=%0d vld=%b to=%b want 08/3/1/0", gnt, gnt_idx, gnt_vld, timeout);
        end
        req = 8'h00;
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        int         order_full [9]   = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
        int         order_sparse [3] = '{5, 1, 5};
        logic [7:0] eg;
        do_reset();
        mode = 1'b1;
        req  = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            eg = 8'h01 << order_full[k];
            total++;
            if (obs !== {eg, 3'(order_full[k]), 1'b1, 1'b0}) begin
                bad++;
                $display("[TB] FAIL rr_full[%0d] got gnt=%h idx=%0d vld=%b want %h/%0d/1", k, gnt, gnt_idx, gnt_vld, eg, order_full[k]);
            end
            done = 1'b1;
            @(negedge clk);
            done = 1'b0;
            total++;
            if (gnt_vld !== 1'b0 || gnt !== 8'h00) begin
                bad++;
                $display("[TB] FAIL rr_gap[%0d] got gnt=%h vld=%b want 00/0", k, gnt, gnt_vld);
            end
        end
        do_reset();
        mode = 1'b1;
        req  = 8'h22;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            eg = 8'h01 << order_sparse[k];
            total++;
            if (obs !== {eg, 3'(order_sparse[k]), 1'b1, 1'b0}) begin
                bad++;
                $display("[TB] FAIL rr_sparse[%0d] got gnt=%h idx=%0d vld=%b want %h/%0d/1", k, gnt, gnt_idx, gnt_vld, eg, order_sparse[k]);
            end
            done = 1'b1;
            @(negedge clk);
            done = 1'b0;
        end
        req  = 8'h00;
        mode = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_watchdog();
        do_reset();
        mode = 1'b0;
        req  = 8'h01;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            total++;
            if (obs !== {8'h01, 3'd0, 1'b1, 1'b0}) begin
                bad++;
                $display("[TB] FAIL wd_hold[%0d] got gnt=%h idx=%0d vld=%b to=%b want 01/0/1/0", c, gnt, gnt_idx, gnt_vld, timeout);
            end
        end
        @(negedge clk);
        total++;
        if (obs !== {8'h00, 3'd0, 1'b0, 1'b1}) begin
            bad++;
            $display("[TB] FAIL wd_expire got gnt=%h idx=%0d vld=%b to=%b want 00/0/0/1", gnt, gnt_idx, gnt_vld, timeout);
        end
        @(negedge clk);
        total++;
        if (obs !== {8'h01, 3'd0, 1'b1, 1'b0}) begin
            bad++;
            $display("[TB] FAIL wd_regrant got gnt=%h idx=%0d vld=%b to=%b want 01/0/1/0", gnt, gnt_idx, gnt_vld, timeout);
        end
        repeat (3) @(negedge clk);
        total++;
        if (gnt_vld !== 1'b1) begin
            bad++;
            $display("[TB] FAIL wd_last_cycle got vld=%b want 1", gnt_vld);
        end
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        total++;
        if (obs !== {8'h00, 3'd0, 1'b0, 1'b0}) begin
            bad++;
            $display("[TB] FAIL wd_done_same_cycle got gnt=%h vld=%b to=%b want 00/0/0", gnt, gnt_vld, timeout);
        end
        req = 8'h00;
        @(negedge clk);
    endtask

    task automatic test_withdraw();
        do_reset();
        mode = 1'b0;
        req  = 8'h40;
        @(negedge clk);
        total++;
        if (obs !== {8'h40, 3'd6, 1'b1, 1'b0}) begin
            bad++;
            $display("[TB] FAIL wdr_grant got gnt=%h idx=%0d vld=%b want 40/6/1", gnt, gnt_idx, gnt_vld);
        end
        req = 8'hC0;
        @(negedge clk);
        total++;
        if (obs !== {8'h40, 3'd6, 1'b1, 1'b0}) begin
            bad++;
            $display("[TB] FAIL wdr_no_preempt got gnt=%h idx=%0d vld=%b want 40/6/1", gnt, gnt_idx, gnt_vld);
        end
        req = 8'h80;
        @(negedge clk);
        total++;
        if (obs !== {8'h00, 3'd0, 1'b0, 1'b0}) begin
            bad++;
            $display("[TB] FAIL wdr_release got gnt=%h vld=%b to=%b want 00/0/0", gnt, gnt_vld, timeout);
        end
        @(negedge clk);
        total++;
        if (obs !== {8'h80, 3'd7, 1'b1, 1'b0}) begin
            bad++;
            $display("[TB] FAIL wdr_next got gnt=%h idx=%0d vld=%b want 80/7/1", gnt, gnt_idx, gnt_vld);
        end
        req = 8'h00;
        @(negedge clk);
    endtask

    task automatic test_mid_reset();
        do_reset();
        mode = 1'b1;
        req  = 8'hFF;
        @(negedge clk);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        @(negedge clk);
        total++;
        if (obs !== {8'h40, 3'd6, 1'b1, 1'b0}) begin
            bad++;
            $display("[TB] FAIL mrst_pre got gnt=%h idx=%0d vld=%b want 40/6/1", gnt, gnt_idx, gnt_vld);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if (obs !== {8'h00, 3'd0, 1'b0, 1'b0}) begin
            bad++;
            $display("[TB] FAIL mrst_drop got gnt=%h idx=%0d vld=%b to=%b want 00/0/0/0", gnt, gnt_idx, gnt_vld, timeout);
        end
        @(negedge clk);
        total++;
        if (obs !== {8'h80, 3'd7, 1'b1, 1'b0}) begin
            bad++;
            $display("[TB] FAIL mrst_ptr got gnt=%h idx=%0d vld=%b want 80/7/1", gnt, gnt_idx, gnt_vld);
        end
        req  = 8'h00;
        mode = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst  = 1'b1;
        req  = 8'h00;
        done = 1'b0;
        mode = 1'b0;
        test_reset();
        test_fixed();
        test_round_robin();
        test_watchdog();
        test_withdraw();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prio_arb_ctrl.md
Name: prio_arb_ctrl

Overview:
Arbiter that shares one downstream resource between 8 requesters, built around the team's 8-input priority-encoding scheme (highest index wins). It adds registered grants, hold-until-done ownership, an optional round-robin rotation, and a hold-time watchdog. It sits between the requester bank and the shared resource and drives a one-hot grant plus an encoded owner index.

Parameters:
MAX_HOLD, 16, maximum grant duration in cycles without done; 0 disables the watchdog
CNT_W, 5, hold counter width; must satisfy 2^CNT_W > MAX_HOLD

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
req  input  8  request vector, bit k = requester k
done  input  1  current owner finished; ignored when gnt_vld=0
mode  input  1  0 = fixed priority (7 highest), 1 = round-robin
gnt  output  8  one-hot grant, registered
gnt_idx  output  3  encoded index of the owner, registered
gnt_vld  output  1  a grant is active
timeout  output  1  one-cycle pulse when the watchdog revokes a grant

Behaviour:
- Reset (synchronous, rst=1 at the edge): gnt=0, gnt_idx=0, gnt_vld=0, timeout=0, state=IDLE, hold_cnt=0, ptr=0. Reset asserted mid-grant drops the grant at that edge. No timeout pulse is generated.
- States: IDLE, BUSY.
- IDLE: if req!=0, at the next edge load gnt/gnt_idx with the winner, set gnt_vld=1, hold_cnt=0, ptr=winner, and go to BUSY. If req==0, stay in IDLE with outputs 0. Latency from req to gnt is 1 cycle.
- Fixed mode: the winner is the highest set bit of req.
- Round-robin mode: search descending from ptr-1, wrapping from 0 to 7, and ending at ptr. The first set bit wins. After reset ptr=0, so the search order is 7,6,...,0, which matches fixed mode.
- mode is sampled only in the IDLE arbitration cycle. Changing mode in BUSY has no effect on the current grant.
- ptr updates on every grant in both modes.
- BUSY: hold the grant and increment hold_cnt each cycle. Release at the next edge (gnt=0, gnt_idx=0, gnt_vld=0, state=IDLE) when any of these holds:
  (a) done=1
  (b) req[gnt_idx]=0, meaning the owner withdrew
  (c) MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1
- On the release edge, timeout=1 only for cause (c) with done=0 and req[gnt_idx]=1. timeout returns to 0 on the following edge.
- gnt_vld is high for at most MAX_HOLD consecutive cycles.
- After every release there is exactly one dead cycle (IDLE, gnt_vld=0) before the next grant. This is also true when other requests are pending.
- Requests from non-owners during BUSY are ignored and are not queued. A requester must hold req until granted.
- gnt is always one-hot or zero. gnt_idx equals the encoding of gnt whenever gnt_vld=1.
- done and a watchdog expiry in the same cycle: release with timeout=0.

Test Plan:
- Reset: assert rst for 2 cycles with req=8'hFF -> gnt=0, gnt_vld=0, timeout=0. The first grant arrives one cycle after rst deasserts, with gnt_idx=7.
- Fixed priority, mode=0: req=8'h2C -> next cycle gnt=8'h20, gnt_idx=5. Pulse done -> one cycle later gnt_vld=0. One cycle after that, gnt=8'h08, gnt_idx=3.
- Round-robin, mode=1: req=8'hFF held, done pulsed on the first cycle of each grant -> grant order 7,6,5,4,3,2,1,0,7. The grant pattern is 1 cycle granted, 1 cycle idle.
- Watchdog, MAX_HOLD=4: req=8'h01 held, done=0 -> gnt_vld high exactly 4 cycles, timeout=1 on the cycle gnt drops, one idle cycle, then gnt_idx=0 again.
- Owner withdrawal and mid-grant reset: owner 6 drops req[6] in BUSY -> gnt cleared next edge, timeout=0. Separately, rst=1 during BUSY -> all outputs 0 at that edge, and with req=8'hFF the first grant after reset is index 7 (ptr restored to 0).
